// File: rtl/alloc_wide.sv
// Wide allocation stage: buffers uop groups from RA0 in a skid FIFO and dispatches them whole to RS0.
// Optional perf counters are enabled with the ALLOC_WIDE_PERF_CNT_EN macro.

package alloc_wide_pkg;
  localparam int NUM_SOURCES = 2;

  typedef logic [4:0] t_gpr_id;
  typedef logic [5:0] t_preg_id;
  typedef logic [3:0] t_ldq_id;
  typedef logic [3:0] t_stq_id;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ALU    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4
  } t_opcode;

  typedef struct packed {
    t_opcode opcode;
    t_gpr_id src1;
    t_gpr_id src2;
    t_gpr_id dst;
  } t_uinstr;

  typedef struct packed {
    t_preg_id psrc1;
    t_preg_id psrc2;
    t_preg_id pdst;
  } t_rename_pkt;

  typedef struct packed {
    t_ldq_id ldqid;
    t_stq_id stqid;
  } t_mem_meta;

  typedef struct packed {
    t_mem_meta mem;
  } t_uop_meta;

  typedef struct packed {
    t_uinstr     uinstr;
    t_rename_pkt rename;
    t_uop_meta   meta;
  } t_disp_pkt;

  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  function automatic logic uop_is_ldst(input t_uinstr u);
    return (u.opcode == OP_LOAD) || (u.opcode == OP_STORE);
  endfunction
endpackage

module alloc_wide
  import alloc_wide_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int SKID_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  t_nuke_pkt                             nuke_rb1,
  input  logic        [WIDTH-1:0]               valid_ra0,
  input  t_uinstr     [WIDTH-1:0]               uinstr_ra0,
  input  t_rename_pkt [WIDTH-1:0]               rename_ra0,
  output logic                                  alloc_ready_ra0,
  output t_gpr_id     [WIDTH-1:0][NUM_SOURCES-1:0] src_addr_ra0,
  input  logic                                  rs_stall_rs0,
  input  logic                                  ldq_stall_rs0,
  input  logic                                  stq_stall_rs0,
  input  t_ldq_id     [WIDTH-1:0]               ldqid_alloc_rs0,
  input  t_stq_id     [WIDTH-1:0]               stqid_alloc_rs0,
  output logic        [WIDTH-1:0]               disp_valid_rs0,
  output t_disp_pkt   [WIDTH-1:0]               disp_pkt_rs0,
`ifdef ALLOC_WIDE_PERF_CNT_EN
  output logic        [31:0]                    perf_stall_cyc,
  output logic        [31:0]                    perf_disp_uops,
`endif
  output logic        [$clog2(SKID_DEPTH+1)-1:0] alloc_occ
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  typedef struct packed {
    logic        [WIDTH-1:0] mask;
    t_uinstr     [WIDTH-1:0] uinstr;
    t_rename_pkt [WIDTH-1:0] rename;
    t_uop_meta   [WIDTH-1:0] meta;
  } t_group;

  t_group             mem_q [SKID_DEPTH];
  t_group             wr_grp;
  t_group             head_grp;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               head_valid;
  logic               stall_rs0;
  logic               enq;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign stall_rs0       = rs_stall_rs0 | ldq_stall_rs0 | stq_stall_rs0;
  assign head_valid      = (occ_q != '0);
  assign alloc_ready_ra0 = (occ_q < OCC_W'(SKID_DEPTH));
  assign enq             = alloc_ready_ra0 & (|valid_ra0) & ~nuke_rb1.valid;
  assign head_grp        = mem_q[head_q];
  assign disp_valid_rs0  = (head_valid & ~stall_rs0 & ~nuke_rb1.valid) ? head_grp.mask : '0;
  assign pop             = |disp_valid_rs0;
  assign alloc_occ       = occ_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    wr_grp        = '0;
    wr_grp.mask   = valid_ra0;
    wr_grp.uinstr = uinstr_ra0;
    wr_grp.rename = rename_ra0;
    for (int i = 0; i < WIDTH; i++) begin
      src_addr_ra0[i][0] = uinstr_ra0[i].src1;
      src_addr_ra0[i][1] = uinstr_ra0[i].src2;
    end
  end

  // Load/store lanes pick up their queue ids at dispatch time; others carry the stored meta.
  always_comb begin
    disp_pkt_rs0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      disp_pkt_rs0[i].uinstr = head_grp.uinstr[i];
      disp_pkt_rs0[i].rename = head_grp.rename[i];
      disp_pkt_rs0[i].meta   = head_grp.meta[i];
      if (uop_is_ldst(head_grp.uinstr[i])) begin
        disp_pkt_rs0[i].meta.mem = {ldqid_alloc_rs0[i], stqid_alloc_rs0[i]};
      end
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (nuke_rb1.valid) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (enq) tail_d = ptr_inc(tail_q);
      if (pop) head_d = ptr_inc(head_q);
      case ({enq, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // NOTE: payload storage has no reset; occupancy alone decides whether a slot is live.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= wr_grp;
  end

`ifdef ALLOC_WIDE_PERF_CNT_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [31:0] disp_uops_q, disp_uops_d;
  logic [32:0] disp_sum;

  assign disp_sum = {1'b0, disp_uops_q} + 33'($countones(disp_valid_rs0));

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    if (head_valid && stall_rs0 && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + 32'd1;
    disp_uops_d = disp_sum[32] ? '1 : disp_sum[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cyc_q <= '0;
      disp_uops_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      disp_uops_q <= disp_uops_d;
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_disp_uops = disp_uops_q;
`endif

endmodule

// File: tb/tb_alloc_wide.sv
// Directed bench for alloc_wide: a default (depth 2) instance and a depth-3 instance for wrap-around.
// Inputs change on the falling edge; outputs are checked 1 ns later.

module tb_alloc_wide;
  import alloc_wide_pkg::*;

  logic                     clk;
  logic                     reset;
  t_nuke_pkt                nuke;
  logic        [1:0]        valid;
  t_uinstr     [1:0]        uinstr;
  t_rename_pkt [1:0]        rename;
  logic                     rs_stall, ldq_stall, stq_stall;
  t_ldq_id     [1:0]        ldqid;
  t_stq_id     [1:0]        stqid;

  logic                     ready2, ready3;
  t_gpr_id     [1:0][1:0]   src2_addr, src3_addr;
  logic        [1:0]        disp2, disp3;
  t_disp_pkt   [1:0]        pkt2, pkt3;
  logic        [1:0]        occ2, occ3;

  int total = 0;
  int bad   = 0;

`ifdef ALLOC_WIDE_PERF_CNT_EN
  logic [31:0] ps2, pd2, ps3, pd3;
`endif

  alloc_wide #(.WIDTH(2), .SKID_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset), .nuke_rb1(nuke),
    .valid_ra0(valid), .uinstr_ra0(uinstr), .rename_ra0(rename),
    .alloc_ready_ra0(ready2), .src_addr_ra0(src2_addr),
    .rs_stall_rs0(rs_stall), .ldq_stall_rs0(ldq_stall), .stq_stall_rs0(stq_stall),
    .ldqid_alloc_rs0(ldqid), .stqid_alloc_rs0(stqid),
    .disp_valid_rs0(disp2), .disp_pkt_rs0(pkt2),
`ifdef ALLOC_WIDE_PERF_CNT_EN
    .perf_stall_cyc(ps2), .perf_disp_uops(pd2),
`endif
    .alloc_occ(occ2)
  );

  alloc_wide #(.WIDTH(2), .SKID_DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .nuke_rb1(nuke),
    .valid_ra0(valid), .uinstr_ra0(uinstr), .rename_ra0(rename),
    .alloc_ready_ra0(ready3), .src_addr_ra0(src3_addr),
    .rs_stall_rs0(rs_stall), .ldq_stall_rs0(ldq_stall), .stq_stall_rs0(stq_stall),
    .ldqid_alloc_rs0(ldqid), .stqid_alloc_rs0(stqid),
    .disp_valid_rs0(disp3), .disp_pkt_rs0(pkt3),
`ifdef ALLOC_WIDE_PERF_CNT_EN
    .perf_stall_cyc(ps3), .perf_disp_uops(pd3),
`endif
    .alloc_occ(occ3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic offer(input logic [1:0] m, input int id, input t_opcode op0, input t_opcode op1);
    valid = m;
    uinstr[0] = '{opcode: op0, src1: 5'd0, src2: 5'(id), dst: 5'(id)};
    uinstr[1] = '{opcode: op1, src1: 5'd1, src2: 5'(id), dst: 5'(id)};
    rename[0] = '{psrc1: 6'(id), psrc2: 6'd0, pdst: 6'(id)};
    rename[1] = '{psrc1: 6'(id), psrc2: 6'd1, pdst: 6'(id)};
  endtask

  task automatic idle();
    valid = 2'b00;
  endtask

  initial begin
    int sent, got, occ_m;
    logic ready_m, pop_m, stall_m;
    int exp_q[$];

    reset = 1'b1;
    nuke = '0; valid = '0; uinstr = '0; rename = '0;
    rs_stall = 1'b0; ldq_stall = 1'b0; stq_stall = 1'b0;
    ldqid = '0; stqid = '0;
    #2 reset = 1'b0;

    // Reset: a valid group offered while reset is held must not be taken.
    @(negedge clk); offer(2'b11, 1, OP_ALU, OP_ALU); #1;
    check("rst_occ", 32'(occ2), 0);
    check("rst_ready", 32'(ready2), 1);
    check("rst_disp", 32'(disp2), 0);
    @(negedge clk); #1;
    check("rst_disp_hold", 32'(disp2), 0);
    check("rst_occ_hold", 32'(occ2), 0);

    // Combinational source address fan-out.
    @(negedge clk); reset = 1'b1; idle();
    uinstr[0].src1 = 5'd3; uinstr[0].src2 = 5'd7; uinstr[1].src1 = 5'd9; uinstr[1].src2 = 5'd30; #1;
    check("src_l0_s1", 32'(src2_addr[0][0]), 3);
    check("src_l0_s2", 32'(src2_addr[0][1]), 7);
    check("src_l1_s1", 32'(src2_addr[1][0]), 9);
    check("src_l1_s2", 32'(src2_addr[1][1]), 30);

    // Single group: accepted in cycle 0, dispatched in cycle 1, empty in cycle 2.
    @(negedge clk); offer(2'b11, 1, OP_ALU, OP_ALU); #1;
    check("single_ready_c0", 32'(ready2), 1);
    check("single_disp_c0", 32'(disp2), 0);
    @(negedge clk); idle(); #1;
    check("single_disp_c1", 32'(disp2), 2'b11);
    check("single_occ_c1", 32'(occ2), 1);
    check("single_dst_c1", 32'(pkt2[1].uinstr.dst), 1);
    @(negedge clk); #1;
    check("single_occ_c2", 32'(occ2), 0);
    check("single_disp_c2", 32'(disp2), 0);

    // Fill under a 4-cycle stall with a group offered every cycle.
    @(negedge clk); rs_stall = 1'b1; offer(2'b11, 2, OP_ALU, OP_ALU); #1;
    check("fill_ready_c0", 32'(ready2), 1);
    @(negedge clk); offer(2'b11, 3, OP_ALU, OP_ALU); #1;
    check("fill_ready_c1", 32'(ready2), 1);
    check("fill_disp_c1", 32'(disp2), 0);
    check("fill_occ_c1", 32'(occ2), 1);
    @(negedge clk); offer(2'b11, 4, OP_ALU, OP_ALU); #1;
    check("fill_ready_c2", 32'(ready2), 0);
    check("fill_occ_c2", 32'(occ2), 2);
    check("fill_disp_c2", 32'(disp2), 0);
    @(negedge clk); rs_stall = 1'b0; ldq_stall = 1'b1; offer(2'b11, 5, OP_ALU, OP_ALU); #1;
    check("fill_ready_c3", 32'(ready2), 0);
    check("fill_disp_c3", 32'(disp2), 0);
    @(negedge clk); ldq_stall = 1'b0; idle(); #1;
    check("fill_disp_c4", 32'(disp2), 2'b11);
    check("fill_dst_c4", 32'(pkt2[0].uinstr.dst), 2);
    check("fill_occ_c4", 32'(occ2), 2);
    @(negedge clk); #1;
    check("fill_disp_c5", 32'(disp2), 2'b11);
    check("fill_dst_c5", 32'(pkt2[0].uinstr.dst), 3);
    check("fill_occ_c5", 32'(occ2), 1);
    @(negedge clk); #1;
    check("fill_occ_c6", 32'(occ2), 0);
    check("fill_disp_c6", 32'(disp2), 0);

    // Full FIFO with stall released and a new group offered: pop now, accept next cycle.
    @(negedge clk); stq_stall = 1'b1; offer(2'b11, 6, OP_ALU, OP_ALU);
    @(negedge clk); offer(2'b11, 7, OP_ALU, OP_ALU);
    @(negedge clk); stq_stall = 1'b0; offer(2'b11, 8, OP_ALU, OP_ALU); #1;
    check("full_occ_c2", 32'(occ2), 2);
    check("full_ready_c2", 32'(ready2), 0);
    check("full_disp_c2", 32'(disp2), 2'b11);
    check("full_dst_c2", 32'(pkt2[1].uinstr.dst), 6);
    @(negedge clk); #1;
    check("full_occ_c3", 32'(occ2), 1);
    check("full_ready_c3", 32'(ready2), 1);
    check("full_dst_c3", 32'(pkt2[1].uinstr.dst), 7);
    @(negedge clk); idle(); #1;
    check("full_occ_c4", 32'(occ2), 1);
    check("full_dst_c4", 32'(pkt2[1].uinstr.dst), 8);
    @(negedge clk); #1;
    check("full_occ_c5", 32'(occ2), 0);

    // Nuke with two groups buffered, then nuke into an empty FIFO with a group offered.
    @(negedge clk); rs_stall = 1'b1; offer(2'b11, 9, OP_ALU, OP_ALU);
    @(negedge clk); offer(2'b11, 10, OP_ALU, OP_ALU);
    @(negedge clk); rs_stall = 1'b0; nuke.valid = 1'b1; offer(2'b11, 11, OP_ALU, OP_ALU); #1;
    check("nuke_occ_c2", 32'(occ2), 2);
    check("nuke_disp_c2", 32'(disp2), 0);
    check("nuke_ready_c2", 32'(ready2), 0);
    @(negedge clk); offer(2'b11, 12, OP_ALU, OP_ALU); #1;
    check("nuke_occ_c3", 32'(occ2), 0);
    check("nuke_ready_c3", 32'(ready2), 1);
    check("nuke_disp_c3", 32'(disp2), 0);
    @(negedge clk); nuke.valid = 1'b0; idle(); #1;
    check("nuke_occ_c4", 32'(occ2), 0);
    check("nuke_disp_c4", 32'(disp2), 0);

    // Load/store meta: lane 1 load gets ldq/stq ids, lane 0 ALU keeps zero meta.
    @(negedge clk); offer(2'b11, 13, OP_ALU, OP_LOAD);
    @(negedge clk); idle(); ldqid[1] = 4'd5; stqid[1] = 4'd2; ldqid[0] = 4'd9; stqid[0] = 4'd6; #1;
    check("meta_disp", 32'(disp2), 2'b11);
    check("meta_l1_ldqid", 32'(pkt2[1].meta.mem.ldqid), 5);
    check("meta_l1_stqid", 32'(pkt2[1].meta.mem.stqid), 2);
    check("meta_l0_zero", 32'(pkt2[0].meta), 0);
    // Single-lane store group.
    @(negedge clk); offer(2'b01, 14, OP_STORE, OP_ALU);
    @(negedge clk); idle(); ldqid[0] = 4'd3; stqid[0] = 4'd4; #1;
    check("meta_partial_disp", 32'(disp2), 2'b01);
    check("meta_st_l0", 32'(pkt2[0].meta), 8'h34);
    @(negedge clk); #1;
    check("meta_occ_after", 32'(occ2), 0);

    // Reset asserted mid-operation with groups buffered.
    @(negedge clk); rs_stall = 1'b1; offer(2'b11, 15, OP_ALU, OP_ALU);
    @(negedge clk); offer(2'b11, 16, OP_ALU, OP_ALU);
    @(negedge clk); idle(); #1;
    check("midrst_occ_before", 32'(occ2), 2);
    reset = 1'b0; #1;
    check("midrst_occ", 32'(occ2), 0);
    check("midrst_ready", 32'(ready2), 1);
    check("midrst_disp", 32'(disp2), 0);
    @(negedge clk); reset = 1'b1; rs_stall = 1'b0; #1;
    check("midrst_disp_rel", 32'(disp2), 0);
    @(negedge clk); #1;
    check("midrst_disp_after", 32'(disp2), 0);
    check("midrst_occ_after", 32'(occ2), 0);

    // Wrap-around on the depth-3 instance: 7 groups, stall alternating each cycle.
    sent = 0; got = 0; occ_m = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      stall_m  = (c % 2 == 0);
      rs_stall = stall_m;
      if (sent < 7) offer(2'b11, 17 + sent, OP_ALU, OP_ALU);
      else idle();
      #1;
      ready_m = (occ_m < 3);
      pop_m   = (occ_m > 0) && !stall_m;
      check("wrap_ready", 32'(ready3), 32'(ready_m));
      check("wrap_disp", 32'(disp3), pop_m ? 32'd3 : 32'd0);
      if (pop_m) begin
        check("wrap_order", 32'(pkt3[0].uinstr.dst), 32'(exp_q.pop_front()));
        got++;
        occ_m--;
      end
      if (ready_m && sent < 7) begin
        exp_q.push_back(17 + sent);
        sent++;
        occ_m++;
      end
    end
    rs_stall = 1'b0;
    check("wrap_sent", 32'(sent), 7);
    check("wrap_got", 32'(got), 7);
    check("wrap_occ_end", 32'(occ3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alloc_wide.md
ALLOC_WIDE -- requirements
Module: alloc_wide

Interface
REQ-001 SHALL have parameter WIDTH, default 2, number of uop lanes allocated per cycle (1..4).
REQ-002 SHALL have parameter SKID_DEPTH, default 2, number of uop groups buffered between RA0 and RS0 (1..8, need not be a power of 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port nuke_rb1  input  t_nuke_pkt  pipeline flush; only .valid is used.
REQ-006 SHALL have port valid_ra0  input  [WIDTH]  per-lane uop valid; valid lanes contiguous from lane 0.
REQ-007 SHALL have ports uinstr_ra0 and rename_ra0  input  t_uinstr[WIDTH] / t_rename_pkt[WIDTH]  per-lane uop and rename info.
REQ-008 SHALL have port alloc_ready_ra0  output  1  group accept permission.
REQ-009 SHALL have port src_addr_ra0  output  t_gpr_id[WIDTH][NUM_SOURCES]  per-lane src1/src2 opreg, combinational from uinstr_ra0.
REQ-010 SHALL have ports rs_stall_rs0, ldq_stall_rs0, stq_stall_rs0  input  1 each  downstream backpressure.
REQ-011 SHALL have ports ldqid_alloc_rs0 and stqid_alloc_rs0  input  t_ldq_id[WIDTH] / t_stq_id[WIDTH]  per-lane queue ids.
REQ-012 SHALL have ports disp_valid_rs0 and disp_pkt_rs0  output  [WIDTH] / t_disp_pkt[WIDTH]  per-lane dispatch.
REQ-013 SHALL have port alloc_occ  output  $clog2(SKID_DEPTH+1)  number of buffered groups.

Function
REQ-014 SHALL accept a group when alloc_ready_ra0 and any valid_ra0 bit are high and nuke_rb1.valid is low; the group stores the lane valid mask, uinstr, rename, and meta='0.
REQ-015 SHALL drive alloc_ready_ra0 = (alloc_occ < SKID_DEPTH); it SHALL NOT depend combinationally on the stall inputs.
REQ-016 SHALL hold accepted groups in a circular FIFO with head/tail pointers wrapping SKID_DEPTH-1 -> 0; groups SHALL dispatch in acceptance order.
REQ-017 SHALL have latency exactly 1 cycle: a group accepted into an empty FIFO in cycle N is presented at RS0 in cycle N+1.
REQ-018 SHALL define stall_rs0 = rs_stall_rs0 | ldq_stall_rs0 | stq_stall_rs0.
REQ-019 SHALL set disp_valid_rs0[i] = head_valid & head_mask[i] & ~stall_rs0 & ~nuke_rb1.valid.
REQ-020 SHALL pop the head group in any cycle where some disp_valid_rs0 bit is high; the whole group dispatches together and is never split.
REQ-021 SHALL set disp_pkt_rs0[i].meta.mem = {ldqid_alloc_rs0[i], stqid_alloc_rs0[i]} when uop_is_ldst(head uop[i]); otherwise meta SHALL be the stored value.
REQ-022 SHALL allow enqueue and pop in the same cycle; occupancy stays unchanged, including when full (the pop frees the slot only for the following cycle).
REQ-023 SHALL, on nuke_rb1.valid, block enqueue, suppress dispatch, and clear the FIFO so that alloc_occ=0 in the next cycle.
REQ-024 SHALL keep alloc_occ in 0..SKID_DEPTH; it SHALL never overflow or underflow.

Reset
REQ-025 SHALL, while reset=0, clear the pointers and alloc_occ to 0, hold disp_valid_rs0=0 and alloc_ready_ra0=1, and clear the performance counters.
REQ-026 SHALL discard all in-flight groups on reset asserted mid-operation; no dispatch occurs in the cycle after deassertion.

Configuration
REQ-027 SHALL, with ALLOC_WIDE_PERF_CNT_EN defined, add outputs perf_stall_cyc (32b, increments each cycle head_valid & stall_rs0) and perf_disp_uops (32b, adds popcount(disp_valid_rs0) each cycle); both counters saturate at all-ones.
REQ-028 SHALL, without ALLOC_WIDE_PERF_CNT_EN, omit those ports and counters entirely, with all other behaviour unchanged.

Verification
REQ-029 SHALL verify the single group: WIDTH=2, mask 2'b11 in cycle 0, no stall -> disp_valid_rs0=2'b11 in cycle 1, alloc_occ returns to 0 in cycle 2.
REQ-030 SHALL verify fill under stall: stall held 4 cycles with groups offered every cycle, SKID_DEPTH=2 -> exactly 2 groups accepted, alloc_ready_ra0=0 from the cycle after the 2nd accept, groups dispatched in order after the stall drops.
REQ-031 SHALL verify simultaneous enqueue and pop at full: occupancy 2, stall low, new group offered -> alloc_ready_ra0=0 that cycle, one pop, then accept in the next cycle.
REQ-032 SHALL verify nuke: nuke_rb1.valid with occupancy 2 and a new group offered -> disp_valid_rs0=0 and no accept that cycle, alloc_occ=0 in the next cycle.
REQ-033 SHALL verify load/store meta: lane 1 is a load, lane 0 is an ALU op, ldqid_alloc_rs0[1]=5 -> disp_pkt_rs0[1].meta.mem.ldqid=5 and disp_pkt_rs0[0].meta=0.
REQ-034 SHALL verify wrap-around: SKID_DEPTH=3, 7 groups with alternating stall -> all 7 groups dispatch in order with no loss or duplication.
